backward_burst_arbiter: RTL and testbench
=========================================

Name: backward_burst_arbiter

Overview:
- Per-master response-path arbiter for the crossbar. One instance per master port.
- Selects which slave response FIFO may drain into this master's response FIFO, using round-robin order.
- Holds the grant for a whole burst, until the beat flagged last, so beats from different slaves never interleave.
- Pops the granted slave FIFO and pushes the master FIFO, counts beats, and flags runaway bursts.

Parameters:
- masters, 2, number of master ports; must be >= 2.
- slaves, 2, number of slave ports; must be >= 2.
- i_am_master_number, 0, index of the master this instance serves.
- max_beats, 256, beat limit per burst before a forced release.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous active-high reset.
- slave_fifo_empty  in  1 x [0:slaves-1]  slave response FIFO empty flags.
- slave_master_dest  in  [$clog2(masters)-1:0] x [0:slaves-1]  destination master of each FIFO head beat.
- slave_fifo_last  in  1 x [0:slaves-1]  FIFO head beat is the last beat of its burst.
- master_fifo_full  in  1  this master's response FIFO is full.
- grant_valid  out  1  a burst is locked to grant_slave_number.
- grant_slave_number  out  [$clog2(slaves)-1:0]  granted slave; steers the datapath mux.
- slave_fifo_pop  out  [slaves-1:0]  one-hot pop for the granted slave FIFO.
- master_fifo_push  out  1  push into this master's response FIFO.
- beat_count  out  [$clog2(max_beats+1)-1:0]  beats transferred in the current burst.
- burst_error  out  1  sticky: a burst reached max_beats without a last beat.

Behaviour:
- Request vector: req[i] = ~slave_fifo_empty[i] & (slave_master_dest[i] == i_am_master_number).
- States: IDLE, LOCKED.
- Reset, asynchronous, any time including mid-burst:
  - state = IDLE, rr_ptr = 0, grant_slave_number = 0.
  - grant_valid = 0, beat_count = 0, burst_error = 0.
  - slave_fifo_pop = 0 and master_fifo_push = 0 immediately.
- IDLE with any req bit set:
  - Winner = first set req[i] searching from rr_ptr upward, modulo slaves.
  - At the next clock edge: grant_slave_number <= winner, grant_valid <= 1, state <= LOCKED.
  - Latency: grant appears 1 cycle after the request; no transfer happens in the IDLE cycle.
- IDLE with no request: hold; grant_slave_number keeps its last value.
- LOCKED:
  - fire = req[grant_slave_number] & ~master_fifo_full. Combinational in the same cycle.
  - slave_fifo_pop[grant_slave_number] = fire; master_fifo_push = fire. All other pop bits are 0.
  - On each fire, beat_count increments.
- End of burst (LOCKED):
  - Normal end: fire & slave_fifo_last[grant_slave_number]. Then state <= IDLE, grant_valid <= 0, beat_count <= 0, rr_ptr <= (grant_slave_number + 1) mod slaves.
  - Forced end: fire with beat_count == max_beats-1 and last not set. Then burst_error <= 1, and release exactly as for a normal end.
- One bubble cycle (IDLE) separates consecutive bursts.
- Stall cases while LOCKED:
  - Granted FIFO empty, or its head beat is destined to another master: no pop, lock held, beat_count held.
  - master_fifo_full = 1: no pop, no push, lock held.
  - Requests from other slaves are ignored until release.
- rr_ptr wraps from slaves-1 to 0. The rotation is anchored to the last winner, so a single requester is regranted repeatedly.
- burst_error is cleared only by reset.
- A one-beat burst (last set on its first beat) is legal: 1 fire, then release.

Test Plan:
- Slaves 0 and 1 both request master 0, each with a 3-beat burst, rr_ptr=0 → grant slave 0 with 3 pushes; bubble; grant slave 1 with 3 pushes; then rr_ptr=0.
- Slave 1 only, 1-beat bursts back-to-back → pattern grant, push, IDLE repeats every 2 cycles; grant_slave_number=1 each time.
- master_fifo_full asserted for 4 cycles mid-burst after beat 2 of 4 → no pops for 4 cycles; beat_count stays 2; burst completes after full deasserts; the other slave stays unserved until release.
- Granted slave FIFO runs empty for 3 cycles mid-burst while slave 0 requests → lock held on the granted slave; slave 0 is not granted until the last beat is popped.
- max_beats=4, burst with no last beat → 4 pushes, then burst_error=1, release, rr_ptr advances.
- ARESET asserted while LOCKED at beat 2 → outputs drop to 0 immediately (pop, push, grant_valid, beat_count); after release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/backward_burst_arbiter.sv
// rtl/backward_burst_arbiter.sv - per-master response-path round-robin burst arbiter
module backward_burst_arbiter #(
  parameter int masters            = 2,
  parameter int slaves             = 2,
  parameter int i_am_master_number = 0,
  parameter int max_beats          = 256
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic                             slave_fifo_empty  [0:slaves-1],
  input  logic [$clog2(masters)-1:0]       slave_master_dest [0:slaves-1],
  input  logic                             slave_fifo_last   [0:slaves-1],
  input  logic                             master_fifo_full,
  output logic                             grant_valid,
  output logic [$clog2(slaves)-1:0]        grant_slave_number,
  output logic [slaves-1:0]                slave_fifo_pop,
  output logic                             master_fifo_push,
  output logic [$clog2(max_beats+1)-1:0]   beat_count,
  output logic                             burst_error
);

  localparam int SW = $clog2(slaves);
  localparam int MW = $clog2(masters);
  localparam int BW = $clog2(max_beats+1);
  localparam logic [MW-1:0] my_id     = MW'(i_am_master_number);
  localparam logic [BW-1:0] beat_limit = BW'(max_beats-1);
  localparam logic [SW-1:0] last_slave = SW'(slaves-1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   rr_ptr;
  logic [slaves-1:0] req;
  logic [SW-1:0]   winner;
  logic            any_req;
  logic            fire;
  logic            last_beat;
  logic            at_limit;
  logic            end_burst;

  // A slave requests when its head beat is present and belongs to this master
  always_comb begin
    req = '0;
    for (int i = 0; i < slaves; i++) begin
      req[i] = ~slave_fifo_empty[i] & (slave_master_dest[i] == my_id);
    end
  end

  // Round-robin pick: scan downward so the candidate closest to rr_ptr wins
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int k = slaves-1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % slaves]) begin
        winner = SW'((int'(rr_ptr) + k) % slaves);
      end
    end
  end

  assign grant_valid = (state == LOCKED);
  assign fire        = grant_valid & req[grant_slave_number] & ~master_fifo_full;
  assign last_beat   = slave_fifo_last[grant_slave_number];
  assign at_limit    = (beat_count == beat_limit);
  assign end_burst   = fire & (last_beat | at_limit);

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and transfer strobes; pops only ever target the locked slave
  always_comb begin
    state_next       = state;
    slave_fifo_pop   = '0;
    master_fifo_push = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        slave_fifo_pop[grant_slave_number] = fire;
        master_fifo_push                   = fire;
        if (end_burst) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant latch, rotation pointer, beat counter and sticky runaway flag
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr_ptr             <= '0;
      grant_slave_number <= '0;
      beat_count         <= '0;
      burst_error        <= 1'b0;
    end else begin
      if ((state == IDLE) && any_req) begin
        grant_slave_number <= winner;
      end
      if (end_burst) begin
        beat_count <= '0;
        rr_ptr     <= (grant_slave_number == last_slave) ? '0
                                                         : grant_slave_number + SW'(1);
        if (!last_beat) begin
          burst_error <= 1'b1;
        end
      end else if (fire) begin
        beat_count <= beat_count + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_backward_burst_arbiter.sv
// tb/tb_backward_burst_arbiter.sv - directed bench for backward_burst_arbiter
module tb_backward_burst_arbiter;

  logic       ACLK;
  logic       ARESET;
  logic       slave_fifo_empty  [0:1];
  logic [0:0] slave_master_dest [0:1];
  logic       slave_fifo_last   [0:1];
  logic       master_fifo_full;
  logic       grant_valid;
  logic [0:0] grant_slave_number;
  logic [1:0] slave_fifo_pop;
  logic       master_fifo_push;
  logic [2:0] beat_count;
  logic       burst_error;

  int total;
  int bad;

  // bench-side slave FIFO contents
  logic dest_mem [0:1][0:31];
  logic last_mem [0:1][0:31];
  int   head [0:1];
  int   tail [0:1];
  logic mfull;

  backward_burst_arbiter #(
    .masters(2), .slaves(2), .i_am_master_number(0), .max_beats(4)
  ) dut (
    .ACLK               (ACLK),
    .ARESET             (ARESET),
    .slave_fifo_empty   (slave_fifo_empty),
    .slave_master_dest  (slave_master_dest),
    .slave_fifo_last    (slave_fifo_last),
    .master_fifo_full   (master_fifo_full),
    .grant_valid        (grant_valid),
    .grant_slave_number (grant_slave_number),
    .slave_fifo_pop     (slave_fifo_pop),
    .master_fifo_push   (master_fifo_push),
    .beat_count         (beat_count),
    .burst_error        (burst_error)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic flush();
    for (int s = 0; s < 2; s++) begin
      head[s] = 0;
      tail[s] = 0;
    end
  endtask

  task automatic push_beat(input int s, input logic d, input logic l);
    dest_mem[s][tail[s]] = d;
    last_mem[s][tail[s]] = l;
    tail[s]++;
  endtask

  task automatic drive();
    for (int s = 0; s < 2; s++) begin
      slave_fifo_empty[s]  = (head[s] == tail[s]);
      slave_master_dest[s] = (head[s] == tail[s]) ? 1'b0 : dest_mem[s][head[s]];
      slave_fifo_last[s]   = (head[s] == tail[s]) ? 1'b0 : last_mem[s][head[s]];
    end
    master_fifo_full = mfull;
    #1;
  endtask

  task automatic tick();
    logic [1:0] pop_cap;
    pop_cap = slave_fifo_pop;
    @(posedge ACLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (pop_cap[s]) head[s]++;
    end
    drive();
  endtask

  task automatic cyc(input string tag, input int gv, input int gs, input int psh,
                     input int pop, input int bc);
    chk({tag, "_gv"},   int'(grant_valid),        gv);
    chk({tag, "_gs"},   int'(grant_slave_number), gs);
    chk({tag, "_push"}, int'(master_fifo_push),   psh);
    chk({tag, "_pop"},  int'(slave_fifo_pop),     pop);
    chk({tag, "_bc"},   int'(beat_count),         bc);
    tick();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    ARESET = 1'b1;
    mfull  = 1'b0;
    flush();
    drive();
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_gv",   int'(grant_valid), 0);
    chk("rst_gs",   int'(grant_slave_number), 0);
    chk("rst_push", int'(master_fifo_push), 0);
    chk("rst_pop",  int'(slave_fifo_pop), 0);
    chk("rst_bc",   int'(beat_count), 0);
    chk("rst_err",  int'(burst_error), 0);
    ARESET = 1'b0;
    drive();

    // head beat for another master is not a request
    push_beat(0, 1'b1, 1'b1);
    drive();
    cyc("dm0", 0, 0, 0, 0, 0);
    cyc("dm1", 0, 0, 0, 0, 0);
    flush();
    drive();

    // two 3-beat bursts, slave 0 first, bubble between
    for (int b = 0; b < 3; b++) begin
      push_beat(0, 1'b0, b == 2);
      push_beat(1, 1'b0, b == 2);
    end
    drive();
    cyc("t1_idle", 0, 0, 0, 0, 0);
    cyc("t1_a0",   1, 0, 1, 1, 0);
    cyc("t1_a1",   1, 0, 1, 1, 1);
    cyc("t1_a2",   1, 0, 1, 1, 2);
    cyc("t1_bub",  0, 0, 0, 0, 0);
    cyc("t1_b0",   1, 1, 1, 2, 0);
    cyc("t1_b1",   1, 1, 1, 2, 1);
    cyc("t1_b2",   1, 1, 1, 2, 2);
    cyc("t1_end",  0, 1, 0, 0, 0);
    // rotation wrapped back to slave 0
    push_beat(0, 1'b0, 1'b1);
    push_beat(1, 1'b0, 1'b1);
    drive();
    cyc("rr_idle", 0, 1, 0, 0, 0);
    cyc("rr_s0",   1, 0, 1, 1, 0);
    cyc("rr_bub",  0, 0, 0, 0, 0);
    cyc("rr_s1",   1, 1, 1, 2, 0);
    cyc("rr_end",  0, 1, 0, 0, 0);

    // single requester, 1-beat bursts back to back
    flush();
    for (int b = 0; b < 3; b++) push_beat(1, 1'b0, 1'b1);
    drive();
    for (int b = 0; b < 3; b++) begin
      cyc("t2_idle", 0, 1, 0, 0, 0);
      cyc("t2_beat", 1, 1, 1, 2, 0);
    end
    cyc("t2_end", 0, 1, 0, 0, 0);

    // master FIFO full for 4 cycles after beat 2 of 4
    flush();
    for (int b = 0; b < 4; b++) push_beat(0, 1'b0, b == 3);
    push_beat(1, 1'b0, 1'b1);
    drive();
    cyc("t3_idle", 0, 1, 0, 0, 0);
    cyc("t3_b0",   1, 0, 1, 1, 0);
    cyc("t3_b1",   1, 0, 1, 1, 1);
    mfull = 1'b1;
    drive();
    for (int c = 0; c < 4; c++) cyc("t3_full", 1, 0, 0, 0, 2);
    mfull = 1'b0;
    drive();
    cyc("t3_b2",   1, 0, 1, 1, 2);
    cyc("t3_b3",   1, 0, 1, 1, 3);
    cyc("t3_bub",  0, 0, 0, 0, 0);
    cyc("t3_s1",   1, 1, 1, 2, 0);
    cyc("t3_end",  0, 1, 0, 0, 0);
    chk("t3_err", int'(burst_error), 0);

    // granted FIFO runs dry while slave 0 requests
    flush();
    push_beat(1, 1'b0, 1'b0);
    push_beat(1, 1'b0, 1'b0);
    drive();
    cyc("t4_idle", 0, 1, 0, 0, 0);
    cyc("t4_b0",   1, 1, 1, 2, 0);
    cyc("t4_b1",   1, 1, 1, 2, 1);
    push_beat(0, 1'b0, 1'b1);
    drive();
    for (int c = 0; c < 3; c++) cyc("t4_dry", 1, 1, 0, 0, 2);
    push_beat(1, 1'b0, 1'b1);
    drive();
    cyc("t4_b2",   1, 1, 1, 2, 2);
    cyc("t4_bub",  0, 1, 0, 0, 0);
    cyc("t4_s0",   1, 0, 1, 1, 0);
    cyc("t4_end",  0, 0, 0, 0, 0);

    // runaway burst hits the 4-beat limit
    flush();
    for (int b = 0; b < 7; b++) push_beat(0, 1'b0, 1'b0);
    drive();
    cyc("t5_idle", 0, 0, 0, 0, 0);
    cyc("t5_b0",   1, 0, 1, 1, 0);
    cyc("t5_b1",   1, 0, 1, 1, 1);
    cyc("t5_b2",   1, 0, 1, 1, 2);
    chk("t5_err_pre", int'(burst_error), 0);
    cyc("t5_b3",   1, 0, 1, 1, 3);
    chk("t5_err", int'(burst_error), 1);
    cyc("t5_rel",  0, 0, 0, 0, 0);
    chk("t5_err_sticky", int'(burst_error), 1);

    // reset while locked on beat 2
    cyc("t6_b0",   1, 0, 1, 1, 0);
    cyc("t6_b1",   1, 0, 1, 1, 1);
    chk("t6_pre_push", int'(master_fifo_push), 1);
    chk("t6_pre_bc",   int'(beat_count), 2);
    ARESET = 1'b1;
    #1;
    chk("t6_gv",   int'(grant_valid), 0);
    chk("t6_push", int'(master_fifo_push), 0);
    chk("t6_pop",  int'(slave_fifo_pop), 0);
    chk("t6_bc",   int'(beat_count), 0);
    chk("t6_err",  int'(burst_error), 0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    flush();
    push_beat(0, 1'b0, 1'b1);
    push_beat(1, 1'b0, 1'b1);
    drive();
    cyc("t6_idle", 0, 0, 0, 0, 0);
    cyc("t6_s0",   1, 0, 1, 1, 0);
    cyc("t6_bub",  0, 0, 0, 0, 0);
    cyc("t6_s1",   1, 1, 1, 2, 0);
    cyc("t6_end",  0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
